// File: rtl/prim_rom_arb.sv
// Shares one single-port registered-read ROM between NUM_REQ requesters: one read per cycle,
// response one cycle after grant, out-of-range addresses answered with rerr_o. Optional macro:
// PRIM_ROM_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module prim_rom_arb #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic                          rerr_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_rdata_i
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so the default depth (1 << ADDR_WIDTH) is representable.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic                  w_found;
    logic [ID_W-1:0]       w_win;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic                  w_grant;
    logic                  w_err;
    logic                  w_rsp_live;

    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic                  r_rsp_err;

`ifdef PRIM_ROM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_i[ID_W'(i)]) begin
                w_found = 1'b1;
                w_win   = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] r_rr;

    // Search begins just after the last winner and wraps around.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (32'(r_rr) + 32'd1 + 32'(i)) % 32'(NUM_REQ);
            if (!w_found && req_i[ID_W'(idx)]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr <= ID_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_rr <= w_win;
        end
    end
`endif

    assign w_grant    = w_found && rst_ni;
    assign w_win_addr = addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_err      = w_grant && ({1'b0, w_win_addr} >= LP_DEPTH);

    always_comb begin
        gnt_o = '0;
        if (w_grant) begin
            gnt_o[w_win] = 1'b1;
        end
    end

    assign rom_addr_o = (w_grant && !w_err) ? w_win_addr : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant;
            r_rsp_id    <= w_win;
            r_rsp_err   <= w_err;
        end
    end

    // Gating with rst_ni drops a response still in flight when reset arrives.
    assign w_rsp_live = r_rsp_valid && rst_ni;

    always_comb begin
        rvalid_o = '0;
        if (w_rsp_live) begin
            rvalid_o[r_rsp_id] = 1'b1;
        end
    end

    assign rerr_o  = w_rsp_live && r_rsp_err;
    assign rdata_o = (w_rsp_live && !r_rsp_err) ? rom_rdata_i : '0;

endmodule

// File: tb/tb_prim_rom_arb.sv
// Bench for prim_rom_arb: directed vectors with literal expectations plus a per-cycle
// reference model of arbitration, range check and 1-cycle response.
module tb_prim_rom_arb;
    localparam int N     = 2;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [AW-1:0] a0, a1;
    logic [N-1:0]  gnt, rvalid;
    logic          rerr;
    logic [DW-1:0] rdata, rom_rdata;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    prim_rom_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i({a1, a0}),
        .gnt_o(gnt), .rvalid_o(rvalid), .rerr_o(rerr), .rdata_o(rdata),
        .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ROM.
    always @(posedge clk) rom_rdata <= mem[rom_addr[9:0]];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: last winner, and the one read that is in flight.
    int          m_last = N - 1;
    bit          m_pv   = 0;
    int          m_pid  = 0;
    bit          m_perr = 0;
    logic [AW-1:0] m_paddr = '0;

    always @(negedge clk) begin
        int win, idx;
        logic [AW-1:0] wa, e_rom;
        bit e_err;
        logic [N-1:0] e_gnt, e_rv;
        logic [DW-1:0] e_rd;
        win = -1;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
`ifdef PRIM_ROM_ARB_FIXED_PRIO_EN
                idx = i;
`else
                idx = (m_last + 1 + i) % N;
`endif
                if (win < 0 && req[idx]) win = idx;
            end
        end
        e_gnt = '0;
        wa    = (win == 1) ? a1 : a0;
        e_err = (win >= 0) && (int'(wa) >= DEPTH);
        e_rom = (win >= 0 && !e_err) ? wa : '0;
        if (win >= 0) e_gnt[win] = 1'b1;
        e_rv = '0;
        if (rst_n && m_pv) e_rv[m_pid] = 1'b1;
        e_rd = (rst_n && m_pv && !m_perr) ? mem[m_paddr[9:0]] : '0;
        check("model_gnt", 64'(gnt), 64'(e_gnt));
        check("model_rom_addr", 64'(rom_addr), 64'(e_rom));
        check("model_rvalid", 64'(rvalid), 64'(e_rv));
        check("model_rerr", 64'(rerr), 64'(rst_n && m_pv && m_perr));
        check("model_rdata", 64'(rdata), 64'(e_rd));
        if (!rst_n) begin
            m_last = N - 1;
            m_pv   = 0;
        end else begin
            m_pv    = (win >= 0);
            m_pid   = (win >= 0) ? win : 0;
            m_perr  = e_err;
            m_paddr = e_rom;
            if (win >= 0) m_last = win;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; a0 = '0; a1 = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
        mem[16] = 32'hDEAD_BEEF;

        step(); step();
        @(negedge clk);
        check("reset_gnt", 64'(gnt), 64'h0);
        check("reset_rvalid", 64'(rvalid), 64'h0);
        check("reset_rerr", 64'(rerr), 64'h0);
        check("reset_rdata", 64'(rdata), 64'h0);
        check("reset_rom_addr", 64'(rom_addr), 64'h0);

        // Single read
        step(); rst_n = 1'b1; req = 2'b01; a0 = 16'h0010;
        @(negedge clk);
        check("single_gnt", 64'(gnt), 64'h1);
        check("single_rom_addr", 64'(rom_addr), 64'h10);
        step(); req = 2'b00;
        @(negedge clk);
        check("single_rvalid", 64'(rvalid), 64'h1);
        check("single_rdata", 64'(rdata), 64'hDEAD_BEEF);

        // Grant requester 1 alone so contention then starts at requester 0
        step(); req = 2'b10; a1 = 16'h0005;
        @(negedge clk);
        check("solo1_gnt", 64'(gnt), 64'h2);

        // Contention
        for (int c = 0; c < 4; c++) begin
            step(); req = 2'b11; a0 = 16'h0020; a1 = 16'h0030;
            @(negedge clk);
`ifdef PRIM_ROM_ARB_FIXED_PRIO_EN
            check("contend_gnt", 64'(gnt), 64'h1);
            if (c > 0) check("contend_rvalid", 64'(rvalid), 64'h1);
`else
            check("contend_gnt", 64'(gnt), (c % 2 == 0) ? 64'h1 : 64'h2);
            if (c > 0) check("contend_rvalid", 64'(rvalid), (c % 2 == 0) ? 64'h2 : 64'h1);
`endif
        end

        // Back-to-back reads by requester 1
        for (int j = 1; j <= 3; j++) begin
            step(); req = 2'b10; a1 = 16'(j);
            @(negedge clk);
            check("b2b_gnt", 64'(gnt), 64'h2);
            if (j > 1) begin
                check("b2b_rvalid", 64'(rvalid), 64'h2);
                check("b2b_rdata", 64'(rdata), 64'h1000_0000 + 64'(j - 1));
            end
        end
        step(); req = 2'b00;
        @(negedge clk);
        check("b2b_last_rvalid", 64'(rvalid), 64'h2);
        check("b2b_last_rdata", 64'(rdata), 64'h1000_0003);

        // Out of range
        step(); req = 2'b01; a0 = 16'h0400;
        @(negedge clk);
        check("oor_gnt", 64'(gnt), 64'h1);
        check("oor_rom_addr", 64'(rom_addr), 64'h0);
        step(); req = 2'b00;
        @(negedge clk);
        check("oor_rvalid", 64'(rvalid), 64'h1);
        check("oor_rerr", 64'(rerr), 64'h1);
        check("oor_rdata", 64'(rdata), 64'h0);

        // Reset mid-flight
        step(); req = 2'b01; a0 = 16'h0007;
        @(negedge clk);
        check("midrst_gnt", 64'(gnt), 64'h1);
        step(); rst_n = 1'b0; req = 2'b00;
        @(negedge clk);
        check("midrst_rvalid", 64'(rvalid), 64'h0);
        step(); req = 2'b11; a0 = 16'h0008; a1 = 16'h0009;
        @(negedge clk);
        check("inrst_gnt", 64'(gnt), 64'h0);
        check("inrst_rvalid", 64'(rvalid), 64'h0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        check("postrst_gnt", 64'(gnt), 64'h1);
        check("postrst_rvalid", 64'(rvalid), 64'h0);

        // Mixed vectors, some out of range, checked by the model
        for (int i = 0; i < 24; i++) begin
            step();
            req = N'(i % 4);
            a0  = 16'((i * 131) % 1300);
            a1  = 16'((i * 211 + 64) % 1300);
        end
        step(); req = 2'b00;
        step(); step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
